stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause/adjust modes, BCD digit registers and a
// rollover pulse. Every output is a flop; strobes take effect on the edge they are sampled.
module stopwatch_core #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink,
    output logic       wrap_p
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    localparam logic [3:0] MIN_LIM_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_LIM_O = 4'(MAX_MIN % 10);
    localparam logic [3:0] SEC_LIM_T = 4'd5;
    localparam logic [3:0] SEC_LIM_O = 4'd9;

    state_e     state_q, state_d;
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_o_q, min_o_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_o_q, sec_o_d;
    logic       running_q, running_d;
    logic       blink_q, blink_d;
    logic       wrap_q, wrap_d;
    logic [7:0] sec_step, min_step;
    logic       sec_at_lim, min_at_lim;

    // Two-digit BCD increment that returns to 00 after the given limit.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] lim_t, input logic [3:0] lim_o);
        logic [7:0] r;
        if (t == lim_t && o == lim_o) begin
            r = 8'h00;
        end else if (o == 4'd9) begin
            r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, o + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_at_lim(input logic [3:0] t, input logic [3:0] o,
                                        input logic [3:0] lim_t, input logic [3:0] lim_o);
        return (t == lim_t) && (o == lim_o);
    endfunction

    assign sec_step   = bcd_inc(sec_t_q, sec_o_q, SEC_LIM_T, SEC_LIM_O);
    assign min_step   = bcd_inc(min_t_q, min_o_q, MIN_LIM_T, MIN_LIM_O);
    assign sec_at_lim = bcd_at_lim(sec_t_q, sec_o_q, SEC_LIM_T, SEC_LIM_O);
    assign min_at_lim = bcd_at_lim(min_t_q, min_o_q, MIN_LIM_T, MIN_LIM_O);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_PAUSE;
            min_t_q   <= 4'd0;
            min_o_q   <= 4'd0;
            sec_t_q   <= 4'd0;
            sec_o_q   <= 4'd0;
            running_q <= 1'b0;
            blink_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_t_q   <= min_t_d;
            min_o_q   <= min_o_d;
            sec_t_q   <= sec_t_d;
            sec_o_q   <= sec_o_d;
            running_q <= running_d;
            blink_q   <= blink_d;
            wrap_q    <= wrap_d;
        end
    end

    // Clear keeps the adjust session open; otherwise adj dominates pause.
    always_comb begin
        state_d = state_q;
        if (clear_p) begin
            if (state_q != ST_ADJUST) begin
                state_d = ST_PAUSE;
            end
        end else if (state_q != ST_ADJUST) begin
            if (adj) begin
                state_d = ST_ADJUST;
            end else if (pause_p) begin
                state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
        end else if (!adj) begin
            state_d = ST_PAUSE;
        end
    end

    always_comb begin
        min_t_d = min_t_q;
        min_o_d = min_o_q;
        sec_t_d = sec_t_q;
        sec_o_d = sec_o_q;
        blink_d = blink_q;
        wrap_d  = 1'b0;
        if (clear_p) begin
            min_t_d = 4'd0;
            min_o_d = 4'd0;
            sec_t_d = 4'd0;
            sec_o_d = 4'd0;
        end else if (state_q != ST_ADJUST) begin
            if (adj) begin
                blink_d = 1'b0;
            end else if (!pause_p && state_q == ST_RUN && tick_1hz) begin
                {sec_t_d, sec_o_d} = sec_step;
                if (sec_at_lim) begin
                    {min_t_d, min_o_d} = min_step;
                    wrap_d             = min_at_lim;
                end
            end
        end else if (!adj) begin
            blink_d = 1'b0;
        end else if (tick_adj) begin
            // Adjust wraps each field on its own; no carry between fields.
            blink_d = ~blink_q;
            if (sel) begin
                {sec_t_d, sec_o_d} = sec_step;
            end else begin
                {min_t_d, min_o_d} = min_step;
            end
        end
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
    end

    assign min_tens = min_t_q;
    assign min_ones = min_o_q;
    assign sec_tens = sec_t_q;
    assign sec_ones = sec_o_q;
    assign running  = running_q;
    assign blink    = blink_q;
    assign wrap_p   = wrap_q;

    a_digit_range: assert property (@(posedge clk) disable iff (!rst)
        (min_t_q <= 4'd5) && (sec_t_q <= 4'd5) && (min_o_q <= 4'd9) && (sec_o_q <= 4'd9));
    a_blink_adjust_only: assert property (@(posedge clk) disable iff (!rst)
        (state_q != ST_ADJUST) |-> !blink_q);
    a_wrap_single: assert property (@(posedge clk) disable iff (!rst)
        wrap_q |=> !wrap_q);
    a_running_state: assert property (@(posedge clk) disable iff (!rst)
        running_q == (state_q == ST_RUN));

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: the driver pushes expected outputs from
// a minutes/seconds reference model, the monitor pops and compares each cycle.
module tb_stopwatch_core;

  localparam int MAX_MIN = 59;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_adj = 1'b0;
  logic       pause_p = 1'b0;
  logic       clear_p = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink, wrap_p;

  stopwatch_core #(.MAX_MIN(MAX_MIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_adj (tick_adj),
    .pause_p  (pause_p),
    .clear_p  (clear_p),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .blink    (blink),
    .wrap_p   (wrap_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  int m_min, m_sec;
  bit m_run, m_adjust, m_blink, m_wrap;

  function automatic logic [18:0] pack(int mn, int sc, bit r, bit b, bit w);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), r, b, w};
  endfunction

  function void model_reset();
    m_min = 0; m_sec = 0;
    m_run = 0; m_adjust = 0; m_blink = 0; m_wrap = 0;
  endfunction

  function void model_step(bit clr, bit a, bit s, bit p, bit t1, bit ta);
    int total;
    m_wrap = 0;
    if (clr) begin
      m_min = 0; m_sec = 0;
      if (!m_adjust) m_run = 0;
    end else if (!m_adjust && a) begin
      m_adjust = 1; m_run = 0; m_blink = 0;
    end else if (m_adjust && !a) begin
      m_adjust = 0; m_blink = 0;
    end else if (m_adjust) begin
      if (ta) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else   m_min = (m_min + 1) % (MAX_MIN + 1);
        m_blink = !m_blink;
      end
    end else if (p) begin
      m_run = !m_run;
    end else if (m_run && t1) begin
      total = m_min * 60 + m_sec + 1;
      if (total == (MAX_MIN + 1) * 60) begin
        total  = 0;
        m_wrap = 1;
      end
      m_min = total / 60;
      m_sec = total % 60;
    end
  endfunction

  task automatic check_now(input logic [18:0] cexp, input string nm);
    logic [18:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones, running, blink, wrap_p};
    chk_cnt++;
    if (got === cexp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s @%0t: got %0d%0d:%0d%0d run=%0b blink=%0b wrap=%0b, expected %0d%0d:%0d%0d run=%0b blink=%0b wrap=%0b",
               nm, $time, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
               cexp[18:15], cexp[14:11], cexp[10:7], cexp[6:3], cexp[2], cexp[1], cexp[0]);
    end
  endtask

  task automatic step(input bit clr, input bit a, input bit s, input bit p, input bit t1,
                      input bit ta, input bit use_c, input logic [18:0] cexp, input string nm);
    exp_t e;
    @(negedge clk);
    clear_p = clr; adj = a; sel = s; pause_p = p; tick_1hz = t1; tick_adj = ta;
    model_step(clr, a, s, p, t1, ta);
    e.val  = use_c ? cexp : pack(m_min, m_sec, m_run, m_blink, m_wrap);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic s6(input bit clr, input bit a, input bit s, input bit p, input bit t1, input bit ta);
    step(clr, a, s, p, t1, ta, 1'b0, 19'h0, "stream");
  endtask

  task automatic sc(input bit clr, input bit a, input bit s, input bit p, input bit t1, input bit ta,
                    input logic [18:0] cexp, input string nm);
    step(clr, a, s, p, t1, ta, 1'b1, cexp, nm);
  endtask

  task automatic push_zero(input string nm);
    exp_t e;
    e.val  = 19'h0;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    #2000000;
    chk_cnt++;
    $display("FAIL timeout @%0t: stimulus did not complete", $time);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    exp_t        e;
    logic [18:0] got;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {min_tens, min_ones, sec_tens, sec_ones, running, blink, wrap_p};
        chk_cnt++;
        if (got === e.val) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s @%0t: got %0d%0d:%0d%0d run=%0b blink=%0b wrap=%0b, expected %0d%0d:%0d%0d run=%0b blink=%0b wrap=%0b",
                   e.name, $time, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                   e.val[18:15], e.val[14:11], e.val[10:7], e.val[6:3], e.val[2], e.val[1], e.val[0]);
        end
      end
    end
  end

  initial begin
    bit a_lvl, s_lvl, r_clr, r_p, r_t1, r_ta;
    model_reset();
    push_zero("reset_low");
    repeat (2) @(negedge clk);
    check_now(19'h0, "reset_state");
    rst = 1'b1;

    // Run 61 seconds from reset.
    s6(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 61; i++) s6(0, 0, 0, 0, 1, 0);
    sc(0, 0, 0, 0, 0, 0, pack(1, 1, 1, 0, 0), "run_61_ticks");
    s6(1, 0, 0, 0, 0, 0);

    // Preload 59:59 and roll over.
    s6(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) s6(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) s6(0, 1, 1, 0, 0, 1);
    sc(0, 0, 1, 0, 0, 0, pack(59, 59, 0, 0, 0), "preload_5959");
    s6(0, 0, 0, 1, 0, 0);
    sc(0, 0, 0, 0, 1, 0, pack(0, 0, 1, 0, 1), "wrap_pulse");
    sc(0, 0, 0, 0, 0, 0, pack(0, 0, 1, 0, 0), "wrap_one_cycle");

    // Pause on the same edge as a tick.
    for (int i = 0; i < 10; i++) s6(0, 0, 0, 0, 1, 0);
    sc(0, 0, 0, 1, 1, 0, pack(0, 10, 0, 0, 0), "pause_drops_tick");
    for (int i = 0; i < 3; i++) sc(0, 0, 0, 0, 1, 0, pack(0, 10, 0, 0, 0), "paused_ticks_ignored");

    // 62 adjust strobes on seconds.
    s6(1, 0, 0, 0, 0, 0);
    s6(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 61; i++) s6(0, 1, 1, 0, 0, 1);
    sc(0, 1, 1, 0, 0, 1, pack(0, 2, 0, 0, 0), "adj_62_ticks");
    s6(0, 0, 1, 0, 0, 0);

    // Clear beats a tick while running at 12:34.
    s6(1, 0, 0, 0, 0, 0);
    s6(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) s6(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 34; i++) s6(0, 1, 1, 0, 0, 1);
    s6(0, 0, 0, 0, 0, 0);
    sc(0, 0, 0, 1, 0, 0, pack(12, 34, 1, 0, 0), "run_at_1234");
    sc(1, 0, 0, 0, 1, 0, pack(0, 0, 0, 0, 0), "clear_over_tick");

    // Asynchronous reset at 03:21 while running.
    s6(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) s6(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) s6(0, 1, 1, 0, 0, 1);
    s6(0, 0, 0, 0, 0, 0);
    s6(0, 0, 0, 1, 0, 0);
    s6(0, 0, 0, 0, 1, 0);
    s6(0, 0, 0, 0, 1, 0);
    sc(0, 0, 0, 0, 1, 0, pack(3, 21, 1, 0, 0), "at_0321");
    @(posedge clk);
    #3;
    push_zero("async_reset");
    rst = 1'b0;
    model_reset();
    #1;
    check_now(19'h0, "async_reset_immediate");
    repeat (2) @(negedge clk);
    clear_p = 0; adj = 0; sel = 0; pause_p = 0; tick_1hz = 0; tick_adj = 0;
    rst = 1'b1;
    s6(0, 0, 0, 1, 0, 0);
    sc(0, 0, 0, 0, 1, 0, pack(0, 1, 1, 0, 0), "first_after_reset");

    // Randomized traffic.
    a_lvl = 0; s_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) a_lvl = !a_lvl;
      if ($urandom_range(15) == 0) s_lvl = !s_lvl;
      r_clr = ($urandom_range(79) == 0);
      r_p   = ($urandom_range(11) == 0);
      r_t1  = ($urandom_range(2) == 0);
      r_ta  = !r_t1 && !r_p && ($urandom_range(1) == 0);
      s6(r_clr, a_lvl, s_lvl, r_p, r_t1, r_ta);
    end
    s6(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
